ingress_frame_reader: RTL and testbench

INGRESS_FRAME_READER -- requirements
Module: ingress_frame_reader

---
 rtl/ingress_frame_reader_pkg.sv | 31 +++
 rtl/ingress_frame_reader_if.sv | 29 ++
 rtl/ingress_frame_reader_skid_buffer.sv | 67 ++++++
 rtl/ingress_frame_reader.sv | 209 ++++++++++++++++++++
 tb/tb_ingress_frame_reader.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ingress_frame_reader_pkg.sv
// ingress_pkg: definitions shared by the ingress frame reader, its skid buffer
// and its output interface.
//   MAX_FRAME_SIZE  : default largest legal frame length in bytes
//   WORD_BYTES      : bytes carried by one 128-bit data word
//   reader_state_t  : reader state machine encoding
//   words_for_len   : number of 128-bit words a frame of len bytes occupies
//   last_word_bytes : valid bytes in the final word of a frame of len bytes
package ingress_pkg;

    localparam int MAX_FRAME_SIZE = 1522;
    localparam int WORD_BYTES     = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HDR_WAIT  = 3'd1,
        DATA_WAIT = 3'd2,
        STREAM    = 3'd3,
        DISCARD   = 3'd4
    } reader_state_t;

    // An 11-bit length needs up to 128 words, so the result is 8 bits wide;
    // a 7-bit count would wrap to 0 for lengths above 2032.
    function automatic logic [7:0] words_for_len(input logic [10:0] len);
        return 8'(len >> 4) + {7'd0, |len[3:0]};
    endfunction

    function automatic logic [4:0] last_word_bytes(input logic [10:0] len);
        return (len[3:0] == 4'd0) ? 5'(WORD_BYTES) : {1'b0, len[3:0]};
    endfunction

endpackage

// File: rtl/ingress_frame_reader_if.sv
// ingress_frame_reader_if: output word stream from the frame reader to the
// memory arbiter.
//   out_valid / out_ready : handshake, one beat per cycle with both high
//   out_data              : frame word, first byte in the top byte lane
//   out_start / out_last  : first / final word of a frame
//   out_bytes_valid       : valid bytes in the word (16, or 1..16 on out_last)
//   out_frame_len         : byte length of the frame being streamed
// Modports: master = reader side, slave = arbiter side.
interface ingress_frame_reader_if #(
    parameter int DATA_WIDTH = 128
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_start;
    logic                  out_last;
    logic [4:0]            out_bytes_valid;
    logic [10:0]           out_frame_len;

    modport master (
        output out_valid, out_data, out_start, out_last, out_bytes_valid, out_frame_len,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_start, out_last, out_bytes_valid, out_frame_len,
        output out_ready
    );
endinterface

// File: rtl/ingress_frame_reader_skid_buffer.sv
// ingress_skid_buffer: 2-entry FIFO that decouples the data FIFO read latency
// from output back-pressure. Synchronous active-low reset empties it and
// clears the stored words so the output reads as zero.
//   clk_mem, rst_n                 : clock, synchronous active-low reset
//   in_valid / in_ready / in_data  : write side
//   out_valid / out_ready/out_data : read side, head entry shown combinationally
//   count                          : entries currently held (0..2)
module ingress_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_mem,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] entry_data [2];

    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = entry_data[rd_ptr_reg];
    assign count     = count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [WIDTH-1:0] data_reg;

            always_ff @(posedge clk_mem) begin
                if (!rst_n) begin
                    data_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= in_data;
                end
            end

            assign entry_data[gi] = data_reg;
        end
    endgenerate

    always_ff @(posedge clk_mem) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/ingress_frame_reader.sv
// ingress_frame_reader: pops frame lengths from a header FIFO and the matching
// 128-bit words from a data FIFO, and streams each frame to the memory arbiter
// with start/last/byte-count sideband. Oversize frames are drained from the
// data FIFO and counted in drop_count; zero-length headers are skipped.
//   clk_mem, rst_n                   : clock, synchronous active-low reset
//   hdr_rd_empty/hdr_rd_en/hdr_rd_data : length FIFO, data 1 cycle after pop
//   data_rd_size/data_rd_en/data_rd_data : data FIFO, data 1 cycle after pop
//   out_if (master)                  : output word stream
//   drop_count                       : saturating count of discarded frames
//   frame_count, byte_count          : statistics, active only when the
//                                      INGRESS_READER_STATS_EN macro is defined
// Only DATA_WIDTH = 128 is supported.
module ingress_frame_reader #(
    parameter int MAX_FRAME_SIZE = ingress_pkg::MAX_FRAME_SIZE,
    parameter int DATA_WIDTH     = 128
) (
    input  logic                  clk_mem,
    input  logic                  rst_n,
    input  logic                  hdr_rd_empty,
    output logic                  hdr_rd_en,
    input  logic [10:0]           hdr_rd_data,
    input  logic [9:0]            data_rd_size,
    output logic                  data_rd_en,
    input  logic [DATA_WIDTH-1:0] data_rd_data,
    ingress_frame_reader_if.master out_if,
    output logic [15:0]           drop_count,
    output logic [31:0]           frame_count,
    output logic [31:0]           byte_count
);
    import ingress_pkg::*;

    // Skid word layout: {start, last, bytes_valid[4:0], data}
    localparam int SKID_W = DATA_WIDTH + 7;

    reader_state_t state_reg, state_next;

    logic [10:0]       len_reg;
    logic [7:0]        words_reg;
    logic [7:0]        popped_reg;
    logic              inflight_reg;
    logic              tag_start_reg;
    logic              tag_last_reg;
    logic [4:0]        tag_bytes_reg;
    logic [15:0]       drop_count_reg;

    logic              skid_in_ready;
    logic              skid_out_valid;
    logic [SKID_W-1:0] skid_in_data;
    logic [SKID_W-1:0] skid_out_data;
    logic [1:0]        skid_count;

    logic              hdr_is_zero;
    logic              hdr_too_long;
    logic [7:0]        remaining;
    logic [1:0]        slots_used;
    logic              pop_is_last;
    logic              beat_fire;
    logic              beat_last;

    assign hdr_is_zero  = (hdr_rd_data == 11'd0);
    assign hdr_too_long = (int'(hdr_rd_data) > MAX_FRAME_SIZE);
    assign remaining    = words_reg - popped_reg;
    // Words already committed downstream: held in the skid plus the one read
    // whose data has not returned yet. Capping this at 2 guarantees the skid
    // always has room for a returning word.
    assign slots_used   = skid_count + {1'b0, inflight_reg};
    assign pop_is_last  = (popped_reg == words_reg - 8'd1);
    assign beat_last    = skid_out_data[SKID_W-2];
    assign beat_fire    = skid_out_valid && out_if.out_ready;

    always_ff @(posedge clk_mem) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hdr_rd_en  = 1'b0;
        data_rd_en = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!hdr_rd_empty) begin
                    hdr_rd_en  = 1'b1;
                    state_next = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                if (hdr_is_zero) begin
                    state_next = IDLE;
                end else if (hdr_too_long) begin
                    state_next = DISCARD;
                end else begin
                    state_next = DATA_WAIT;
                end
            end
            DATA_WAIT: begin
                // The header can become visible before all of its words have
                // crossed into the data FIFO; wait for the whole frame.
                if (data_rd_size >= {2'b00, words_reg}) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if ((popped_reg != words_reg) && (slots_used < 2'd2) && skid_in_ready) begin
                    data_rd_en = 1'b1;
                end
                if (beat_fire && beat_last) begin
                    state_next = IDLE;
                end
            end
            DISCARD: begin
                if (popped_reg == words_reg) begin
                    state_next = IDLE;
                end else if (data_rd_size >= {2'b00, remaining}) begin
                    data_rd_en = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // FIFO pops stay low for the whole time reset is asserted.
        if (!rst_n) begin
            hdr_rd_en  = 1'b0;
            data_rd_en = 1'b0;
        end
    end

    always_ff @(posedge clk_mem) begin
        if (!rst_n) begin
            len_reg        <= '0;
            words_reg      <= '0;
            popped_reg     <= '0;
            inflight_reg   <= 1'b0;
            tag_start_reg  <= 1'b0;
            tag_last_reg   <= 1'b0;
            tag_bytes_reg  <= '0;
            drop_count_reg <= '0;
        end else begin
            if (state_reg == HDR_WAIT) begin
                len_reg    <= hdr_rd_data;
                words_reg  <= words_for_len(hdr_rd_data);
                popped_reg <= '0;
            end else if (data_rd_en) begin
                popped_reg <= popped_reg + 8'd1;
            end
            // Discard pops never enter the skid buffer.
            inflight_reg  <= data_rd_en && (state_reg == STREAM);
            // Sideband is decided at pop time and travels with the word.
            tag_start_reg <= (popped_reg == 8'd0);
            tag_last_reg  <= pop_is_last;
            tag_bytes_reg <= pop_is_last ? last_word_bytes(len_reg) : 5'(WORD_BYTES);
            if ((state_reg == HDR_WAIT) && !hdr_is_zero && hdr_too_long
                    && (drop_count_reg != 16'hFFFF)) begin
                drop_count_reg <= drop_count_reg + 16'd1;
            end
        end
    end

    assign skid_in_data = {tag_start_reg, tag_last_reg, tag_bytes_reg, data_rd_data};

    ingress_skid_buffer #(
        .WIDTH (SKID_W)
    ) u_skid (
        .clk_mem   (clk_mem),
        .rst_n     (rst_n),
        .in_valid  (inflight_reg),
        .in_ready  (skid_in_ready),
        .in_data   (skid_in_data),
        .out_valid (skid_out_valid),
        .out_ready (out_if.out_ready),
        .out_data  (skid_out_data),
        .count     (skid_count)
    );

    assign out_if.out_valid       = skid_out_valid;
    assign out_if.out_start       = skid_out_data[SKID_W-1];
    assign out_if.out_last        = beat_last;
    assign out_if.out_bytes_valid = skid_out_data[SKID_W-3 -: 5];
    assign out_if.out_data        = skid_out_data[DATA_WIDTH-1:0];
    // len_reg only changes in HDR_WAIT, which cannot be reached until the
    // last beat of the current frame has been accepted.
    assign out_if.out_frame_len   = len_reg;
    assign drop_count             = drop_count_reg;

`ifdef INGRESS_READER_STATS_EN
    logic [31:0] frame_count_reg;
    logic [31:0] byte_count_reg;

    always_ff @(posedge clk_mem) begin
        if (!rst_n) begin
            frame_count_reg <= '0;
            byte_count_reg  <= '0;
        end else if (beat_fire && beat_last) begin
            frame_count_reg <= frame_count_reg + 32'd1;
            byte_count_reg  <= byte_count_reg + {21'd0, len_reg};
        end
    end

    assign frame_count = frame_count_reg;
    assign byte_count  = byte_count_reg;
`else
    assign frame_count = '0;
    assign byte_count  = '0;
`endif
endmodule

// File: tb/tb_ingress_frame_reader.sv
module tb_ingress_frame_reader;

    logic         clk_mem = 1'b0;
    logic         rst_n;
    logic         hdr_rd_empty;
    logic         hdr_rd_en;
    logic [10:0]  hdr_rd_data;
    logic [9:0]   data_rd_size;
    logic         data_rd_en;
    logic [127:0] data_rd_data;
    logic [15:0]  drop_count;
    logic [31:0]  frame_count;
    logic [31:0]  byte_count;
    logic         rdy;

    always #5 clk_mem = ~clk_mem;

    ingress_frame_reader_if #(.DATA_WIDTH(128)) out_if ();
    assign out_if.out_ready = rdy;

    ingress_frame_reader #(
        .MAX_FRAME_SIZE (1522),
        .DATA_WIDTH     (128)
    ) dut (
        .clk_mem      (clk_mem),
        .rst_n        (rst_n),
        .hdr_rd_empty (hdr_rd_empty),
        .hdr_rd_en    (hdr_rd_en),
        .hdr_rd_data  (hdr_rd_data),
        .data_rd_size (data_rd_size),
        .data_rd_en   (data_rd_en),
        .data_rd_data (data_rd_data),
        .out_if       (out_if),
        .drop_count   (drop_count),
        .frame_count  (frame_count),
        .byte_count   (byte_count)
    );

    typedef struct {
        logic [127:0] data;
        logic         start;
        logic         last;
        logic [4:0]   bytes;
        logic [10:0]  len;
    } beat_t;

    beat_t        exp_q[$];
    logic [10:0]  hq[$];
    logic [127:0] dq[$];
    logic [9:0]   cap = 10'd1023;
    int           total = 0;
    int           bad = 0;
    int           pops_total = 0;
    int           beats_total = 0;
    logic [31:0]  exp_frames = 0;
    logic [31:0]  exp_bytes = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_word(input int fid, input int idx);
        logic [31:0] a;
        logic [31:0] b;
        a = fid;
        b = idx;
        return {a, b, a ^ 32'h5A5A_0F0F, ~b};
    endfunction

    // Source FIFO models: registered read data, sizes visible after a clock.
    initial begin
        forever begin
            int n;
            @(posedge clk_mem);
            if (!rst_n) begin
                hq.delete();
                dq.delete();
                hdr_rd_data  <= '0;
                data_rd_data <= '0;
            end else begin
                if (hdr_rd_en) begin
                    chk("hdr_underflow", (hq.size() == 0), 0);
                    if (hq.size() != 0) hdr_rd_data <= hq.pop_front();
                end
                if (data_rd_en) begin
                    chk("data_underflow", (dq.size() == 0), 0);
                    if (dq.size() != 0) begin
                        data_rd_data <= dq.pop_front();
                        pops_total++;
                    end
                end
            end
            n = dq.size();
            hdr_rd_empty <= (hq.size() == 0);
            data_rd_size <= (n > int'(cap)) ? cap : 10'(n);
        end
    end

    // Monitor: checks every accepted beat against the scoreboard and checks
    // that a stalled beat is held unchanged.
    initial begin
        logic         hold;
        logic [159:0] saved;
        logic [159:0] cur;
        beat_t        e;
        hold = 1'b0;
        saved = '0;
        forever begin
            @(negedge clk_mem);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                cur = {out_if.out_valid, out_if.out_start, out_if.out_last,
                       out_if.out_bytes_valid, out_if.out_frame_len, out_if.out_data};
                if (hold) chk("hold_stable", cur, saved);
                if (out_if.out_valid && out_if.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", out_if.out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", cur, {1'b1, e.start, e.last, e.bytes, e.len, e.data});
                        $display("beat len=%0d start=%0b last=%0b bytes=%0d data=%h",
                                 out_if.out_frame_len, out_if.out_start, out_if.out_last,
                                 out_if.out_bytes_valid, out_if.out_data);
                        beats_total++;
                        if (e.last) begin
                            exp_frames = exp_frames + 1;
                            exp_bytes  = exp_bytes + 32'(e.len);
                        end
                    end
                end
                hold  = out_if.out_valid && !out_if.out_ready;
                saved = cur;
            end
        end
    end

    task automatic tick();
        @(posedge clk_mem);
        #1;
    endtask

    task automatic send_frame(input int len, input int fid);
        int    n;
        beat_t b;
        n = (len + 15) / 16;
        for (int i = 0; i < n; i++) begin
            dq.push_back(mk_word(fid, i));
            if (len > 0 && len <= 1522) begin
                b.data  = mk_word(fid, i);
                b.start = (i == 0);
                b.last  = (i == n - 1);
                b.bytes = 5'((i == n - 1) ? (len - 16 * (n - 1)) : 16);
                b.len   = 11'(len);
                exp_q.push_back(b);
            end
        end
        hq.push_back(11'(len));
    endtask

    task automatic wait_drain(input int budget, input bit rand_ready);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && hq.size() == 0 && dq.size() == 0) break;
            if (rand_ready) rdy = 1'($urandom_range(0, 1));
            tick();
        end
        rdy = 1'b1;
        chk("drain_in_budget", (i < budget), 1);
        repeat (4) tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, out_if.out_valid, 0);
        chk({tag, "_start"}, out_if.out_start, 0);
        chk({tag, "_last"}, out_if.out_last, 0);
        chk({tag, "_bytes"}, out_if.out_bytes_valid, 0);
        chk({tag, "_len"}, out_if.out_frame_len, 0);
        chk({tag, "_data"}, out_if.out_data, 0);
        chk({tag, "_hdr_en"}, hdr_rd_en, 0);
        chk({tag, "_data_en"}, data_rd_en, 0);
        chk({tag, "_drop"}, drop_count, 0);
        chk({tag, "_frames"}, frame_count, 0);
        chk({tag, "_bytes_cnt"}, byte_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p0;
        int b0;
        int i;
        rst_n = 1'b0;
        rdy   = 1'b1;
        repeat (4) @(posedge clk_mem);
        @(negedge clk_mem);
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // 64 bytes: 4 full beats
        p0 = pops_total;
        send_frame(64, 1);
        wait_drain(200, 0);
        chk("len64_pops", pops_total - p0, 4);

        // 65 bytes: 5 beats, last carries 1 byte
        send_frame(65, 2);
        wait_drain(200, 0);

        // single-word frame: start and last together
        send_frame(16, 3);
        wait_drain(200, 0);

        // zero-length header: no data pops, no output
        p0 = pops_total;
        send_frame(0, 4);
        wait_drain(200, 0);
        chk("len0_pops", pops_total - p0, 0);

        // data not yet visible: nothing may be popped or emitted
        cap = 10'd2;
        send_frame(64, 5);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_mem);
            chk("wait_no_pop", data_rd_en, 0);
            chk("wait_no_valid", out_if.out_valid, 0);
        end
        tick();
        cap = 10'd1023;
        wait_drain(200, 0);

        // oversize frame: 100 words drained, nothing emitted
        p0 = pops_total;
        send_frame(1600, 6);
        wait_drain(400, 0);
        chk("discard_pops", pops_total - p0, 100);
        chk("drop_count_1", drop_count, 1);

        // largest legal frame with a 5-cycle stall at beat 2
        p0 = pops_total;
        b0 = beats_total;
        send_frame(1522, 7);
        for (i = 0; i < 200; i++) begin
            if (beats_total - b0 >= 2) break;
            tick();
        end
        chk("reach_beat2", (beats_total - b0 >= 2), 1);
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_mem);
            chk("pop_ahead_le2", ((pops_total - p0) - (beats_total - b0) <= 2), 1);
        end
        tick();
        rdy = 1'b1;
        wait_drain(1000, 0);
        chk("max_beats", beats_total - b0, 96);
        chk("max_pops", pops_total - p0, 96);

        // one byte over the limit: dropped
        p0 = pops_total;
        send_frame(1523, 8);
        wait_drain(400, 0);
        chk("discard2_pops", pops_total - p0, 96);
        chk("drop_count_2", drop_count, 2);

        // random back-pressure
        send_frame(200, 9);
        wait_drain(1000, 1);

        // back-to-back headers
        send_frame(48, 12);
        send_frame(33, 13);
        send_frame(17, 14);
        wait_drain(500, 0);

        // reset at beat 3 of a 10-word frame
        b0 = beats_total;
        send_frame(160, 10);
        for (i = 0; i < 300; i++) begin
            if (beats_total - b0 >= 3) break;
            tick();
        end
        chk("reach_beat3", (beats_total - b0 >= 3), 1);
        rst_n = 1'b0;
        exp_q.delete();
        exp_frames = 0;
        exp_bytes  = 0;
        @(negedge clk_mem);
        @(negedge clk_mem);
        check_all_zero("midreset");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        send_frame(32, 11);
        wait_drain(200, 0);

`ifdef INGRESS_READER_STATS_EN
        chk("frame_count", frame_count, exp_frames);
        chk("byte_count", byte_count, exp_bytes);
`else
        chk("frame_count_tied", frame_count, 0);
        chk("byte_count_tied", byte_count, 0);
`endif
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
